// File: rtl/fixed_point_div_ctrl_pkg.sv
// Shared types and defaults for the fixed-point divider control path.
// State encoding plus default iteration geometry.
package fixed_point_div_pkg;

    localparam int DEF_ITERS   = 14;
    localparam int DEF_OV_ITER = 9;
    localparam int DEF_CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        SHIFT,
        CMP,
        DONE
    } div_state_t;

endpackage

// File: rtl/fixed_point_div_ctrl_if.sv
// Handshake, datapath flags and strobes between the divider controller
// and its datapath / requester.
interface fixed_point_div_ctrl_if #(
    parameter int CNT_W = 4
);

    logic             start;
    logic             b_zero;
    logic             gt;
    logic             ov_in;
    logic             ld_a;
    logic             ld_b;
    logic             init;
    logic             shift;
    logic             sub;
    logic             ready;
    logic             busy;
    logic             done;
    logic             ov;
    logic             dz;
    logic [CNT_W-1:0] iter;

    modport master (
        output start,
        output b_zero,
        output gt,
        output ov_in,
        input  ld_a,
        input  ld_b,
        input  init,
        input  shift,
        input  sub,
        input  ready,
        input  busy,
        input  done,
        input  ov,
        input  dz,
        input  iter
    );

    modport slave (
        input  start,
        input  b_zero,
        input  gt,
        input  ov_in,
        output ld_a,
        output ld_b,
        output init,
        output shift,
        output sub,
        output ready,
        output busy,
        output done,
        output ov,
        output dz,
        output iter
    );

endinterface

// File: rtl/fixed_point_div_ctrl_iter_cnt.sv
// Iteration counter for the divider: synchronous clear, enable,
// saturates at LAST so it never wraps mid-divide.
module div_iter_cnt #(
    parameter int CNT_W = 4,
    parameter int LAST  = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

    assign term = (count == LAST_V);

    // Count enabled iterations, holding at the terminal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !term) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fixed_point_div_ctrl.sv
// Restoring-divide sequencer: load, init, then ITERS shift/compare
// pairs, with early exit on divide-by-zero or integer overflow.
module fixed_point_div_ctrl
    import fixed_point_div_pkg::*;
#(
    parameter int ITERS   = DEF_ITERS,
    parameter int OV_ITER = DEF_OV_ITER,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fixed_point_div_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] OV_IDX = CNT_W'(OV_ITER);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(ITERS - 1);

    div_state_t       state;
    logic             ov_q;
    logic             dz_q;
    logic [CNT_W-1:0] iter;
    logic             cnt_term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             in_cmp;
    logic             ov_hit;

    assign in_cmp  = (state == CMP);
    assign ov_hit  = in_cmp && bus.ov_in && (iter == OV_IDX);
    assign cnt_clr = (state == INIT);
    // Only advance when another shift follows, so iter stays in range.
    assign cnt_en  = in_cmp && !ov_hit && !cnt_term;

    div_iter_cnt #(
        .CNT_W (CNT_W),
        .LAST  (ITERS - 1)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (iter),
        .term  (cnt_term)
    );

    // Sequencer state plus sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ov_q  <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        ov_q  <= 1'b0;
                        dz_q  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= INIT;
                end
                INIT: begin
                    if (bus.b_zero) begin
                        dz_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    state <= CMP;
                end
                CMP: begin
                    if (ov_hit) begin
                        ov_q  <= 1'b1;
                        state <= DONE;
                    end else if (cnt_term) begin
                        state <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ld_a  = (state == LOAD);
    assign bus.ld_b  = (state == LOAD);
    assign bus.init  = (state == INIT);
    assign bus.shift = (state == SHIFT);
    assign bus.sub   = in_cmp && bus.gt;
    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE) && (state != DONE);
    assign bus.done  = (state == DONE);
    assign bus.ov    = ov_q;
    assign bus.dz    = dz_q;
    assign bus.iter  = iter;

    a_strobe_excl: assert property (
        @(posedge clk) disable iff (!rst)
        $onehot0({bus.ld_a, bus.init, bus.shift, bus.sub})
    );

    a_iter_range: assert property (
        @(posedge clk) disable iff (!rst)
        iter <= LAST_V
    );

endmodule

// File: doc/fixed_point_div_ctrl.md
FIXED_POINT_DIV_CTRL -- requirements
Module: fixed_point_div_ctrl

Interface
REQ-001 SHALL have parameter ITERS, default 14, meaning quotient-bit iterations per divide.
REQ-002 SHALL have parameter OV_ITER, default 9, meaning iteration index at which datapath overflow is sampled.
REQ-003 SHALL have parameter CNT_W, default 4, meaning iteration counter width; SHALL satisfy 2**CNT_W >= ITERS.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a divide; accepted only when ready=1.
REQ-007 b_zero  input  1  datapath flag: loaded divisor equals 0.
REQ-008 gt  input  1  datapath flag: ACC >= divisor.
REQ-009 ov_in  input  1  datapath flag: quotient integer field non-zero.
REQ-010 ld_a  output  1  load dividend register.
REQ-011 ld_b  output  1  load divisor register.
REQ-012 init  output  1  clear ACC, load Q from dividend.
REQ-013 shift  output  1  shift {ACC,Q} left one bit.
REQ-014 sub  output  1  ACC <= ACC - divisor, set Q[0]=1.
REQ-015 ready  output  1  idle, start accepted this cycle.
REQ-016 busy  output  1  divide in progress.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 ov  output  1  sticky overflow status for last divide.
REQ-019 dz  output  1  sticky divide-by-zero status for last divide.
REQ-020 iter  output  CNT_W  current iteration index (debug).

Function
REQ-021 SHALL implement states IDLE, LOAD, INIT, SHIFT, CMP, DONE.
REQ-022 IDLE: ready=1; start=1 -> LOAD; else stay.
REQ-023 LOAD: ld_a=ld_b=1 for exactly one cycle -> INIT.
REQ-024 INIT: init=1, iter<=0; b_zero=1 -> DONE with dz<=1; else -> SHIFT.
REQ-025 SHIFT: shift=1 for one cycle -> CMP.
REQ-026 CMP: sub=gt (combinational from gt); iter increments on exit.
REQ-027 CMP with iter==OV_ITER and ov_in=1 -> DONE with ov<=1, no further iterations.
REQ-028 CMP with iter==ITERS-1 -> DONE; otherwise -> SHIFT.
REQ-029 DONE: done=1 for one cycle -> IDLE; no datapath strobe active.
REQ-030 Nominal latency: start-accept edge to done=1 SHALL be 2+2*ITERS+1 = 31 cycles at defaults.
REQ-031 ov and dz SHALL clear on the LOAD cycle of the next divide and hold otherwise.
REQ-032 busy SHALL be 1 in LOAD..CMP, 0 in IDLE and DONE; ready SHALL equal (state==IDLE).
REQ-033 start while busy or in DONE SHALL be ignored (no queuing).
REQ-034 At most one of ld_a, init, shift, sub SHALL be active per cycle (ld_a and ld_b pair allowed).
REQ-035 iter SHALL never exceed ITERS-1; no wrap while busy.

Reset
REQ-036 rst=0 SHALL asynchronously force state=IDLE, iter=0, ov=0, dz=0, all strobes 0, done=0, busy=0.
REQ-037 After rst rises, ready=1 on the first clock.
REQ-038 Reset mid-divide SHALL abort without a done pulse.

Structure
REQ-039 Shared package fixed_point_div_pkg SHALL hold the state enumeration and the ITERS/OV_ITER defaults.
REQ-040 Iteration counter SHALL be sub-module div_iter_cnt (clear, enable, count, terminal flag).
REQ-041 FSM SHALL be registered state plus combinational outputs; no latches.

Verification
REQ-042 start=1 one cycle, b_zero=0, ov_in=0 -> ld_a/ld_b once, 14 shift and 14 CMP cycles, done at cycle 31, ov=dz=0.
REQ-043 b_zero=1 at INIT -> done at cycle 3, dz=1, shift never asserted.
REQ-044 ov_in=1 at CMP with iter=9 -> done next cycle, ov=1, exactly 10 shift pulses.
REQ-045 gt alternating 1/0 per CMP -> sub asserted on iterations 0,2,4,...,12 only.
REQ-046 rst=0 at cycle 10 of a divide -> outputs zero immediately, no done, ready=1 after release.
REQ-047 start held high through divide plus next -> second divide begins only after done, ov/dz clear on its LOAD.
